// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory port, decode-side handshake and PC redirect.
// instr_misaligned exists only when FETCH_ALIGN_CHECK_EN is defined.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        instr_misaligned;
`endif

    modport master (
`ifdef FETCH_ALIGN_CHECK_EN
        output instr_misaligned,
`endif
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect_valid, redirect_pc
    );

    modport slave (
`ifdef FETCH_ALIGN_CHECK_EN
        input  instr_misaligned,
`endif
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end: PC owner, req/gnt/rvalid fetch port, in-order instruction FIFO.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned redirect targets instead of masking them.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input logic                clk,
    input logic                rst_n,
    instr_fetch_unit_if.master bus
);
    localparam int          CW      = $clog2(FIFO_DEPTH + 1);
    localparam int          PW      = $clog2(FIFO_DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    typedef enum logic {FETCH = 1'b0, DRAIN = 1'b1} state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] count_q, count_d, outst_q, outst_d, drop_q, drop_d;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic          started_q;

    logic [31:0]   fifo_data [FIFO_DEPTH];
    logic [31:0]   fifo_pc   [FIFO_DEPTH];
    logic [31:0]   tag_pc    [FIFO_DEPTH];

    logic          req, gnt_fire, rv_take, push, pop, pop_fifo, valid_o;
    logic [CW:0]   occ;
    logic [CW-1:0] outst_live;
    logic [31:0]   redir_tgt;
    logic          halt_q, mis_q;
    logic [31:0]   mis_pc_q;

`ifdef FETCH_ALIGN_CHECK_EN
    logic          halt_d, mis_d;
    logic [31:0]   mis_pc_d;
    logic          misaligned;

    assign misaligned = bus.redirect_pc[1:0] != 2'b00;
    assign redir_tgt  = bus.redirect_pc;
`else
    assign halt_q     = 1'b0;
    assign mis_q      = 1'b0;
    assign mis_pc_q   = 32'h0;
    assign redir_tgt  = bus.redirect_pc & ~32'h3;
`endif

    assign occ     = {1'b0, count_q} + {1'b0, outst_q};
    assign valid_o = (count_q != '0) || mis_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        tag_wr_d   = tag_wr_q;
        tag_rd_d   = tag_rd_q;
`ifdef FETCH_ALIGN_CHECK_EN
        halt_d     = halt_q;
        mis_d      = mis_q;
        mis_pc_d   = mis_pc_q;
`endif
        req        = started_q && (state_q == FETCH) && !halt_q && (occ < DEPTH_W);
        gnt_fire   = req && bus.imem_gnt;
        // Stray responses with nothing in flight are dropped so the counter cannot underflow.
        rv_take    = bus.imem_rvalid && (state_q == FETCH) && (outst_q != '0);
        push       = rv_take;
        pop        = valid_o && bus.instr_ready;
        pop_fifo   = pop && !mis_q;
        outst_live = outst_q + CW'(gnt_fire) - CW'(rv_take);
        outst_d    = outst_live;

        if (gnt_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            tag_wr_d   = tag_wr_q + PW'(1);
        end
        if (rv_take)  tag_rd_d = tag_rd_q + PW'(1);
        if (push)     wr_d     = wr_q + PW'(1);
        if (pop_fifo) rd_d     = rd_q + PW'(1);
        count_d = count_q + CW'(push) - CW'(pop_fifo);
`ifdef FETCH_ALIGN_CHECK_EN
        if (pop && mis_q) mis_d = 1'b0;
`endif

        if (state_q == DRAIN) begin
            if (bus.imem_rvalid && drop_q != '0) drop_d = drop_q - CW'(1);
            if (drop_d == '0) state_d = FETCH;
        end

        // Redirect wins over everything: flush the buffer and retarget; a redirect
        // while already draining keeps the pending drop count.
        if (bus.redirect_valid) begin
            count_d    = '0;
            wr_d       = '0;
            rd_d       = '0;
            tag_wr_d   = '0;
            tag_rd_d   = '0;
            outst_d    = '0;
            fetch_pc_d = redir_tgt;
            if (state_q == FETCH) begin
                drop_d  = outst_live;
                state_d = (outst_live != '0) ? DRAIN : FETCH;
            end
`ifdef FETCH_ALIGN_CHECK_EN
            halt_d   = misaligned;
            mis_d    = misaligned;
            mis_pc_d = bus.redirect_pc;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            started_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
            started_q  <= 1'b1;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_q   <= 1'b0;
            mis_q    <= 1'b0;
            mis_pc_q <= 32'h0;
        end else begin
            halt_q   <= halt_d;
            mis_q    <= mis_d;
            mis_pc_q <= mis_pc_d;
        end
    end
`endif

    // Storage needs no reset: occupancy is tracked by the pointers and counters.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_q] <= bus.imem_rdata;
            fifo_pc[wr_q]   <= tag_pc[tag_rd_q];
        end
        if (gnt_fire) tag_pc[tag_wr_q] <= fetch_pc_q;
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = fetch_pc_q;
    assign bus.instr_valid = valid_o;
    assign bus.instr       = (count_q != '0) ? fifo_data[rd_q] : NOP;
    assign bus.instr_pc    = mis_q ? mis_pc_q : ((count_q != '0) ? fifo_pc[rd_q] : 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    assign bus.instr_misaligned = mis_q;
`endif
endmodule
